// File: rtl/axi_boot_loader.sv
// UART-fed boot loader: receives a framed image byte stream, writes each
// 32-bit word to memory over an AXI write channel, verifies an 8-bit sum,
// and releases the CPU reset once the image is fully written and checked.
module axi_boot_loader #(
  parameter logic [31:0] LOAD_BASE = 32'h00000000,
  parameter int          MAX_WORDS = 16384,
  parameter logic [7:0]  SYNC_BYTE = 8'hB0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        cpu_resetn,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE, CNT_LO, CNT_HI, DATA, CSUM, FLUSH, DONE, ERROR
  } rx_state_t;

  typedef enum logic [1:0] {
    W_IDLE, W_XFER, W_RESP
  } wr_state_t;

  // Word count limit widened by one bit so a 16-bit count compares cleanly.
  localparam logic [16:0] MAX_WORDS_C = 17'(MAX_WORDS);

  // Running modulo-256 frame checksum.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

  // Receive side state
  rx_state_t   rx_state_r, rx_state_s;
  logic [7:0]  csum_r, csum_s;
  logic [15:0] cnt_r, cnt_s;
  logic [15:0] idx_r, idx_s;
  logic [1:0]  lane_r, lane_s;
  logic [31:0] asm_r, asm_s;
  logic [15:0] n_s;
  logic        push_s;

  // Write engine state
  wr_state_t   wr_state_r, wr_state_s;
  logic        awvalid_r, awvalid_s;
  logic        wvalid_r, wvalid_s;
  logic        bready_r, bready_s;
  logic [31:0] awaddr_r, awaddr_s;
  logic [31:0] wdata_r, wdata_s;

  // Status outputs
  logic        cpu_resetn_r, done_r, error_r;

  // Frame parser: byte-driven next state, checksum, count and word assembly.
  always_comb begin
    rx_state_s = rx_state_r;
    csum_s     = csum_r;
    cnt_s      = cnt_r;
    idx_s      = idx_r;
    lane_s     = lane_r;
    asm_s      = asm_r;
    push_s     = 1'b0;
    n_s        = {rx_data, cnt_r[7:0]};
    case (rx_state_r)
      IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          csum_s     = 8'h00;
          idx_s      = 16'h0000;
          lane_s     = 2'b00;
          rx_state_s = CNT_LO;
        end else begin
          rx_state_s = IDLE;
        end
      end
      CNT_LO: begin
        if (rx_valid) begin
          cnt_s[7:0] = rx_data;
          csum_s     = csum_add(csum_r, rx_data);
          rx_state_s = CNT_HI;
        end else begin
          rx_state_s = CNT_LO;
        end
      end
      CNT_HI: begin
        if (rx_valid) begin
          cnt_s  = n_s;
          csum_s = csum_add(csum_r, rx_data);
          if ({1'b0, n_s} > MAX_WORDS_C) begin
            rx_state_s = ERROR;
          end else if (n_s == 16'h0000) begin
            rx_state_s = CSUM;
          end else begin
            rx_state_s = DATA;
          end
        end else begin
          rx_state_s = CNT_HI;
        end
      end
      DATA: begin
        if (rx_valid) begin
          asm_s[{lane_r, 3'b000} +: 8] = rx_data;
          csum_s = csum_add(csum_r, rx_data);
          lane_s = lane_r + 2'b01;
          if (lane_r == 2'b11) begin
            // A finished word with the engine still busy means data is lost.
            if (wr_state_r != W_IDLE) begin
              rx_state_s = ERROR;
            end else begin
              push_s = 1'b1;
              idx_s  = idx_r + 16'h0001;
              if (idx_r == (cnt_r - 16'h0001)) begin
                rx_state_s = CSUM;
              end else begin
                rx_state_s = DATA;
              end
            end
          end else begin
            rx_state_s = DATA;
          end
        end else begin
          rx_state_s = DATA;
        end
      end
      CSUM: begin
        if (rx_valid) begin
          if (rx_data != csum_r) begin
            rx_state_s = ERROR;
          end else begin
            rx_state_s = FLUSH;
          end
        end else begin
          rx_state_s = CSUM;
        end
      end
      FLUSH: begin
        // Release the CPU only after the last write has been acknowledged.
        if (wr_state_r == W_IDLE) begin
          rx_state_s = DONE;
        end else begin
          rx_state_s = FLUSH;
        end
      end
      DONE:    rx_state_s = DONE;
      ERROR:   rx_state_s = ERROR;
      default: rx_state_s = IDLE;
    endcase
  end

  // AXI write engine: issue AW/W together, drop each on its handshake, await B.
  always_comb begin
    wr_state_s = wr_state_r;
    awvalid_s  = awvalid_r;
    wvalid_s   = wvalid_r;
    bready_s   = bready_r;
    awaddr_s   = awaddr_r;
    wdata_s    = wdata_r;
    case (wr_state_r)
      W_IDLE: begin
        if (push_s) begin
          awaddr_s   = LOAD_BASE + {14'd0, idx_r, 2'b00};
          wdata_s    = asm_s;
          awvalid_s  = 1'b1;
          wvalid_s   = 1'b1;
          wr_state_s = W_XFER;
        end else begin
          wr_state_s = W_IDLE;
        end
      end
      W_XFER: begin
        awvalid_s = awvalid_r && !mem_axi_awready;
        wvalid_s  = wvalid_r && !mem_axi_wready;
        if (!awvalid_s && !wvalid_s) begin
          bready_s   = 1'b1;
          wr_state_s = W_RESP;
        end else begin
          wr_state_s = W_XFER;
        end
      end
      W_RESP: begin
        if (mem_axi_bvalid) begin
          bready_s   = 1'b0;
          wr_state_s = W_IDLE;
        end else begin
          wr_state_s = W_RESP;
        end
      end
      default: begin
        awvalid_s  = 1'b0;
        wvalid_s   = 1'b0;
        bready_s   = 1'b0;
        wr_state_s = W_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any frame or transaction in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_r   <= IDLE;
      csum_r       <= 8'h00;
      cnt_r        <= 16'h0000;
      idx_r        <= 16'h0000;
      lane_r       <= 2'b00;
      asm_r        <= 32'h0000_0000;
      wr_state_r   <= W_IDLE;
      awvalid_r    <= 1'b0;
      wvalid_r     <= 1'b0;
      bready_r     <= 1'b0;
      awaddr_r     <= 32'h0000_0000;
      wdata_r      <= 32'h0000_0000;
      cpu_resetn_r <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      rx_state_r   <= rx_state_s;
      csum_r       <= csum_s;
      cnt_r        <= cnt_s;
      idx_r        <= idx_s;
      lane_r       <= lane_s;
      asm_r        <= asm_s;
      wr_state_r   <= wr_state_s;
      awvalid_r    <= awvalid_s;
      wvalid_r     <= wvalid_s;
      bready_r     <= bready_s;
      awaddr_r     <= awaddr_s;
      wdata_r      <= wdata_s;
      cpu_resetn_r <= (rx_state_s == DONE);
      done_r       <= (rx_state_s == DONE);
      error_r      <= (rx_state_s == ERROR);
    end
  end

  assign mem_axi_awvalid = awvalid_r;
  assign mem_axi_awaddr  = awaddr_r;
  assign mem_axi_awprot  = 3'b000;
  assign mem_axi_wvalid  = wvalid_r;
  assign mem_axi_wdata   = wdata_r;
  assign mem_axi_wstrb   = 4'b1111;
  assign mem_axi_bready  = bready_r;
  assign cpu_resetn      = cpu_resetn_r;
  assign done            = done_r;
  assign error           = error_r;

endmodule

// File: tb/tb_axi_boot_loader.sv
// Self-checking bench for axi_boot_loader: directed frames plus randomized
// frames checked against a frame-level model of the expected memory writes.
module tb_axi_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, rx_valid;
  logic [7:0]  rx_data;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [2:0]  awprot;
  logic [3:0]  wstrb;
  logic        cpu_resetn, done, error;

  logic        awvalid4, awready4, wvalid4, wready4, bvalid4, bready4;
  logic [31:0] awaddr4, wdata4;
  logic [2:0]  awprot4;
  logic [3:0]  wstrb4;
  logic        cpu_resetn4, done4, error4;

  int n_tests = 0;
  int n_fail  = 0;

  axi_boot_loader dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
    .mem_axi_awprot(awprot), .mem_axi_wvalid(wvalid), .mem_axi_wready(wready),
    .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb), .mem_axi_bvalid(bvalid),
    .mem_axi_bready(bready), .cpu_resetn(cpu_resetn), .done(done), .error(error)
  );

  axi_boot_loader #(.MAX_WORDS(4)) dut4 (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_axi_awvalid(awvalid4), .mem_axi_awready(awready4), .mem_axi_awaddr(awaddr4),
    .mem_axi_awprot(awprot4), .mem_axi_wvalid(wvalid4), .mem_axi_wready(wready4),
    .mem_axi_wdata(wdata4), .mem_axi_wstrb(wstrb4), .mem_axi_bvalid(bvalid4),
    .mem_axi_bready(bready4), .cpu_resetn(cpu_resetn4), .done(done4), .error(error4)
  );

  // Slave model state
  int          aw_hold = 0;
  bit          rnd_mode = 1'b0;
  int          aw_st = 0, w_st = 0, b_st = 0;
  logic [31:0] aw_q[$];
  logic [31:0] w_q[$];
  int          n_b = 0;
  int          n_aw4 = 0;
  bit          prev_aw_stall = 1'b0, prev_w_stall = 1'b0;
  logic [31:0] prev_awaddr, prev_wdata;

  // Reference data
  logic [7:0]  good_f [12] = '{8'hB0, 8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                               8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hE4};
  logic [31:0] exp_words[$];
  logic [7:0]  frame_q[$];

  // AXI slave: drives ready/response on the falling edge and logs the
  // handshakes that the following rising edge will complete.
  always @(negedge clk) begin
    if (reset) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      prev_aw_stall = 1'b0; prev_w_stall = 1'b0;
    end else begin
      if (prev_aw_stall) begin
        n_tests++;
        if (awvalid !== 1'b1 || awaddr !== prev_awaddr) begin
          n_fail++;
          $display("FAIL aw_stable: awvalid=%b awaddr=%h required 1/%h", awvalid, awaddr, prev_awaddr);
        end
      end
      if (prev_w_stall) begin
        n_tests++;
        if (wvalid !== 1'b1 || wdata !== prev_wdata) begin
          n_fail++;
          $display("FAIL w_stable: wvalid=%b wdata=%h required 1/%h", wvalid, wdata, prev_wdata);
        end
      end
      if (aw_hold > 0) begin
        awready = 1'b0; aw_hold--;
      end else if (rnd_mode && aw_st < 2 && $urandom_range(0, 1) == 0) begin
        awready = 1'b0; aw_st++;
      end else begin
        awready = 1'b1; aw_st = 0;
      end
      if (rnd_mode && w_st < 2 && $urandom_range(0, 1) == 0) begin
        wready = 1'b0; w_st++;
      end else begin
        wready = 1'b1; w_st = 0;
      end
      if (((aw_q.size() < w_q.size()) ? aw_q.size() : w_q.size()) > n_b) begin
        if (rnd_mode && b_st < 2 && $urandom_range(0, 1) == 0) begin
          bvalid = 1'b0; b_st++;
        end else begin
          bvalid = 1'b1; b_st = 0;
        end
      end else begin
        bvalid = 1'b0;
      end
      if (awvalid && awready) begin
        aw_q.push_back(awaddr);
        n_tests++;
        if (awprot !== 3'b000) begin
          n_fail++;
          $display("FAIL awprot: got %b required 000", awprot);
        end
      end
      if (wvalid && wready) begin
        w_q.push_back(wdata);
        n_tests++;
        if (wstrb !== 4'hF) begin
          n_fail++;
          $display("FAIL wstrb: got %h required f", wstrb);
        end
      end
      if (bvalid && bready) n_b++;
      prev_aw_stall = awvalid && !awready;
      prev_w_stall  = wvalid && !wready;
      prev_awaddr   = awaddr;
      prev_wdata    = wdata;
    end
    if (awvalid4) n_aw4++;
  end

  task automatic clear_slave();
    aw_q.delete(); w_q.delete(); n_b = 0; aw_hold = 0; n_aw4 = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_slave();
  endtask

  // One byte strobe, then 'gap' idle cycles; always returns 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_end(input int max);
    int k = 0;
    while (!(done || error) && k < max) begin @(posedge clk); #1; k++; end
    n_tests++;
    if (!(done || error)) begin
      n_fail++;
      $display("FAIL wait_end: no done/error after %0d cycles", max);
    end
  endtask

  // Model: frame bytes and checksum from the word list, by plain arithmetic.
  function automatic void build_frame(input bit bad);
    logic [7:0]  sum;
    logic [15:0] n;
    n = 16'(exp_words.size());
    frame_q.delete();
    frame_q.push_back(8'hB0);
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
    sum = n[7:0] + n[15:8];
    foreach (exp_words[i]) begin
      for (int j = 0; j < 4; j++) begin
        frame_q.push_back(8'((exp_words[i] >> (8 * j)) & 32'hFF));
        sum = sum + 8'((exp_words[i] >> (8 * j)) & 32'hFF);
      end
    end
    frame_q.push_back(bad ? sum + 8'h01 : sum);
  endfunction

  task automatic test_reset();
    send_byte(8'hB0, 0);
    send_byte(8'h01, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({awvalid, wvalid, bready, cpu_resetn, done, error} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 000000", {awvalid, wvalid, bready, cpu_resetn, done, error});
    end
    n_tests++;
    if (awaddr !== 32'h0 || wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: awaddr=%h wdata=%h required 0/0", awaddr, wdata);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    clear_slave();
  endtask

  task automatic test_good_frame();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      send_byte(good_f[i], 0);
      if (i == 6) begin
        n_tests++;
        if (awvalid !== 1'b1) begin
          n_fail++;
          $display("FAIL good_latency: awvalid=%b required 1", awvalid);
        end
      end
      if (i == 10) begin
        n_tests++;
        if (done !== 1'b0) begin
          n_fail++;
          $display("FAIL good_early_done: done=%b required 0", done);
        end
      end
      repeat (3) begin @(posedge clk); #1; end
    end
    wait_end(100);
    n_tests++;
    if (done !== 1'b1 || cpu_resetn !== 1'b1 || error !== 1'b0 || n_b != 2) begin
      n_fail++;
      $display("FAIL good_status: done=%b cpu_resetn=%b error=%b b=%0d required 1/1/0/2", done, cpu_resetn, error, n_b);
    end
    n_tests++;
    if (aw_q.size() != 2 || w_q.size() != 2) begin
      n_fail++;
      $display("FAIL good_count: aw=%0d w=%0d required 2/2", aw_q.size(), w_q.size());
    end else begin
      n_tests++;
      if (aw_q[0] !== 32'h0 || aw_q[1] !== 32'h4 || w_q[0] !== 32'h11223344 || w_q[1] !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL good_writes: %h:%h %h:%h required 0:11223344 4:deadbeef", aw_q[0], w_q[0], aw_q[1], w_q[1]);
      end
    end
  endtask

  task automatic test_bad_csum();
    do_reset();
    for (int i = 0; i < 12; i++) send_byte((i == 11) ? 8'hE5 : good_f[i], 3);
    wait_end(100);
    repeat (20) begin @(posedge clk); #1; end
    n_tests++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_resetn !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_status: error=%b done=%b cpu_resetn=%b required 1/0/0", error, done, cpu_resetn);
    end
    n_tests++;
    if (aw_q.size() != 2 || w_q.size() != 2 || n_b != 2) begin
      n_fail++;
      $display("FAIL bad_writes: aw=%0d w=%0d b=%0d required 2/2/2", aw_q.size(), w_q.size(), n_b);
    end
  endtask

  task automatic test_empty();
    logic [7:0] f [6] = '{8'h00, 8'hFF, 8'hB0, 8'h00, 8'h00, 8'h00};
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(f[i], 1);
    wait_end(50);
    n_tests++;
    if (done !== 1'b1 || error !== 1'b0 || cpu_resetn !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_status: done=%b error=%b cpu_resetn=%b required 1/0/1", done, error, cpu_resetn);
    end
    n_tests++;
    if (aw_q.size() != 0 || w_q.size() != 0) begin
      n_fail++;
      $display("FAIL empty_axi: aw=%0d w=%0d required 0/0", aw_q.size(), w_q.size());
    end
  endtask

  task automatic test_size_limit();
    awready4 = 1'b1; wready4 = 1'b1; bvalid4 = 1'b1;
    do_reset();
    send_byte(8'hB0, 0);
    send_byte(8'h05, 0);
    n_tests++;
    if (error4 !== 1'b0) begin
      n_fail++;
      $display("FAIL size_early: error=%b required 0", error4);
    end
    send_byte(8'h00, 0);
    n_tests++;
    if (error4 !== 1'b1) begin
      n_fail++;
      $display("FAIL size_error: error=%b required 1", error4);
    end
    repeat (10) begin @(posedge clk); #1; end
    n_tests++;
    if (n_aw4 != 0) begin
      n_fail++;
      $display("FAIL size_no_aw: awvalid cycles=%0d required 0", n_aw4);
    end
    // Default limit: 16384 words accepted, 16385 rejected.
    do_reset();
    send_byte(8'hB0, 0); send_byte(8'h00, 0); send_byte(8'h40, 2);
    n_tests++;
    if (error !== 1'b0) begin
      n_fail++;
      $display("FAIL size_max_ok: error=%b required 0", error);
    end
    do_reset();
    send_byte(8'hB0, 0); send_byte(8'h01, 0); send_byte(8'h40, 0);
    n_tests++;
    if (error !== 1'b1) begin
      n_fail++;
      $display("FAIL size_max_plus1: error=%b required 1", error);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    aw_hold = 200;
    for (int i = 0; i < 11; i++) send_byte(good_f[i], 0);
    n_tests++;
    if (error !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_error: error=%b required 1", error);
    end
    repeat (250) begin @(posedge clk); #1; end
    n_tests++;
    if (aw_q.size() != 1 || w_q.size() != 1 || n_b != 1) begin
      n_fail++;
      $display("FAIL overrun_count: aw=%0d w=%0d b=%0d required 1/1/1", aw_q.size(), w_q.size(), n_b);
    end else begin
      n_tests++;
      if (aw_q[0] !== 32'h0 || w_q[0] !== 32'h11223344) begin
        n_fail++;
        $display("FAIL overrun_write: %h:%h required 0:11223344", aw_q[0], w_q[0]);
      end
    end
    n_tests++;
    if (error !== 1'b1 || done !== 1'b0 || awvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_final: error=%b done=%b awvalid=%b required 1/0/0", error, done, awvalid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(good_f[i], 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_tests++;
    if ({awvalid, wvalid, bready, cpu_resetn, done, error} !== 6'b0 || awaddr !== 32'h0 || wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_vals: ctrl=%b awaddr=%h wdata=%h required 0", {awvalid, wvalid, bready, cpu_resetn, done, error}, awaddr, wdata);
    end
    clear_slave();
    // Reset while a write is stalled on AW: nothing may be re-issued.
    aw_hold = 50;
    for (int i = 0; i < 7; i++) send_byte(good_f[i], 0);
    repeat (2) begin @(posedge clk); #1; end
    n_tests++;
    if (awvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_inflight: awvalid=%b required 1", awvalid);
    end
    do_reset();
    repeat (30) begin @(posedge clk); #1; end
    n_tests++;
    if (aw_q.size() != 0 || w_q.size() != 0) begin
      n_fail++;
      $display("FAIL mid_reissue: aw=%0d w=%0d required 0/0", aw_q.size(), w_q.size());
    end
    for (int i = 0; i < 12; i++) send_byte(good_f[i], 3);
    wait_end(100);
    n_tests++;
    if (done !== 1'b1 || aw_q.size() != 2) begin
      n_fail++;
      $display("FAIL mid_reload: done=%b aw=%0d required 1/2", done, aw_q.size());
    end else begin
      n_tests++;
      if (aw_q[0] !== 32'h0 || aw_q[1] !== 32'h4) begin
        n_fail++;
        $display("FAIL mid_reload_addr: %h %h required 0 4", aw_q[0], aw_q[1]);
      end
    end
  endtask

  task automatic test_random();
    rnd_mode = 1'b1;
    for (int it = 0; it < 8; it++) begin
      int  n;
      int  g;
      bit  bad;
      do_reset();
      n   = $urandom_range(0, 5);
      bad = ($urandom_range(0, 2) == 0);
      exp_words.delete();
      for (int i = 0; i < n; i++) exp_words.push_back($urandom);
      build_frame(bad);
      g = $urandom_range(0, 2);
      for (int i = 0; i < g; i++) begin
        logic [7:0] gb;
        gb = 8'($urandom_range(0, 255));
        if (gb == 8'hB0) gb = 8'h5A;
        send_byte(gb, 1);
      end
      foreach (frame_q[i]) send_byte(frame_q[i], 3);
      wait_end(200);
      repeat (20) begin @(posedge clk); #1; end
      n_tests++;
      if (error !== bad || done !== !bad || cpu_resetn !== !bad) begin
        n_fail++;
        $display("FAIL rand_status[%0d]: error=%b done=%b cpu_resetn=%b required %b/%b/%b", it, error, done, cpu_resetn, bad, !bad, !bad);
      end
      n_tests++;
      if (aw_q.size() != n || w_q.size() != n || n_b != n) begin
        n_fail++;
        $display("FAIL rand_count[%0d]: aw=%0d w=%0d b=%0d required %0d", it, aw_q.size(), w_q.size(), n_b, n);
      end else begin
        for (int i = 0; i < n; i++) begin
          n_tests++;
          if (aw_q[i] !== 32'(4 * i) || w_q[i] !== exp_words[i]) begin
            n_fail++;
            $display("FAIL rand_write[%0d.%0d]: %h:%h required %h:%h", it, i, aw_q[i], w_q[i], 32'(4 * i), exp_words[i]);
          end
        end
      end
    end
    rnd_mode = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    awready4 = 1'b1; wready4 = 1'b1; bvalid4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_slave();
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_empty();
    test_size_limit();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
